// File: rtl/systolic_sequencer.sv
// systolic_sequencer: start/busy/done run-control for an N x N systolic array.
// On an accepted start it fetches N operand rows (one per cycle), skews each row diagonally
// into the array lanes, lets the array drain, then pulses result_capture and done.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   start, base_addr  operation request (sampled in idle) and row-0 address (latched on accept)
//   busy, done        busy from the cycle after accept through done; done is a one-cycle pulse
//   mem_rd_en/addr    operand row read; mem_rdata returns the following cycle, element i -> lane i
//   array_clear       one-cycle accumulator clear in the first fetch cycle
//   array_data/valid  skewed lane data, forced to zero whenever the lane is not valid
//   result_capture    one-cycle pulse alongside done
module systolic_sequencer #(
  parameter int unsigned MATRIX_SIZE  = 2,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_SIZE-1:0]   mem_rdata [MATRIX_SIZE-1:0],
  output logic                   array_clear,
  output logic [DATA_SIZE-1:0]   array_data [MATRIX_SIZE-1:0],
  output logic [MATRIX_SIZE-1:0] array_valid,
  output logic                   result_capture
);

  // The counter only ever reaches (phase length - 1); the +1 keeps the width >= 1.
  localparam int unsigned CntMax = (MATRIX_SIZE + 1 > DRAIN_CYCLES) ? MATRIX_SIZE + 1
                                                                    : DRAIN_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] FetchLast = CntW'(MATRIX_SIZE - 1);
  localparam logic [CntW-1:0] FlushLast = CntW'(MATRIX_SIZE);
  localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StFlush, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                rvalid_q, rvalid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      base_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    base_d         = base_q;
    busy           = 1'b0;
    done           = 1'b0;
    result_capture = 1'b0;
    mem_rd_en      = 1'b0;
    mem_addr       = '0;
    array_clear    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        busy        = 1'b1;
        mem_rd_en   = 1'b1;
        // Address arithmetic wraps modulo 2^ADDR_W by truncation.
        mem_addr    = base_q + ADDR_W'(cnt_q);
        array_clear = (cnt_q == '0);
        if (cnt_q == FetchLast) begin
          cnt_d   = '0;
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFlush: begin
        busy = 1'b1;
        if (cnt_q == FlushLast) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (cnt_q == DrainLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        busy           = 1'b1;
        done           = 1'b1;
        result_capture = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // mem_rdata is meaningful exactly one cycle after a read strobe.
  assign rvalid_d = mem_rd_en;

  // Lane i: register chain of depth i+1; the last stage drives the array directly.
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    logic [DATA_SIZE-1:0] data_q [i+1];
    logic [DATA_SIZE-1:0] data_d [i+1];
    logic [i:0]           vld_q, vld_d;

    always_comb begin
      data_d[0] = rvalid_q ? mem_rdata[i] : '0;
      vld_d[0]  = rvalid_q;
      for (int s = 1; s <= i; s++) begin
        data_d[s] = data_q[s-1];
        vld_d[s]  = vld_q[s-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s <= i; s++) data_q[s] <= '0;
        vld_q <= '0;
      end else begin
        for (int s = 0; s <= i; s++) data_q[s] <= data_d[s];
        vld_q <= vld_d;
      end
    end

    assign array_data[i]  = data_q[i];
    assign array_valid[i] = vld_q[i];
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
module tb_systolic_sequencer;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int DR  = 2;
  localparam int LAT = 2 * N + 2 + DR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, mem_rd_en, array_clear, result_capture;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata [N-1:0];
  logic [DW-1:0] array_data [N-1:0];
  logic [N-1:0]  array_valid;

  systolic_sequencer #(
    .MATRIX_SIZE (N),
    .DATA_SIZE   (DW),
    .ADDR_W      (AW),
    .DRAIN_CYCLES(DR)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .busy          (busy),
    .done          (done),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .array_clear   (array_clear),
    .array_data    (array_data),
    .array_valid   (array_valid),
    .result_capture(result_capture)
  );

  always #5 clk = ~clk;

  // Current cycle number; stable from just after each rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand memory: one-cycle read latency, garbage when not read.
  logic [DW-1:0] mem [256][N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) mem_rdata[i] <= mem_rd_en ? mem[mem_addr][i] : $urandom();
  end

  typedef struct {
    int            cyc;
    logic [DW-1:0] val;
  } ent_t;

  ent_t addr_q[$];
  ent_t lane_q[N][$];
  int   done_q[$];
  int   busy_from = -5;
  int   busy_until = -5;
  int   idle_from = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void chk(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Reference model: an op accepted at the edge ending cycle c occupies cycles c+1..c+LAT.
  function automatic void accept(input logic [AW-1:0] b);
    int c = cyc;
    logic [AW-1:0] a;
    for (int k = 0; k < N; k++) begin
      a = b + AW'(k);
      addr_q.push_back('{c + 1 + k, DW'(a)});
    end
    for (int r = 0; r < N; r++) begin
      a = b + AW'(r);
      for (int i = 0; i < N; i++) lane_q[i].push_back('{c + r + i + 3, mem[a][i]});
    end
    done_q.push_back(c + LAT);
    busy_from  = c + 1;
    busy_until = c + LAT;
    idle_from  = c + LAT + 1;
  endfunction

  task automatic step(input logic s, input logic [AW-1:0] b);
    start     = s;
    base_addr = b;
    if (s && cyc >= idle_from) accept(b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    start = 1'b0;
    addr_q.delete();
    for (int i = 0; i < N; i++) lane_q[i].delete();
    done_q.delete();
    busy_from  = -5;
    busy_until = -5;
    repeat (n) @(posedge clk);
    #1;
    reset     = 1'b0;
    idle_from = cyc;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic ed, er, ev, eb;
    if (reset) begin
      chk("rst_busy", DW'(busy), '0);
      chk("rst_done", DW'(done), '0);
      chk("rst_rd_en", DW'(mem_rd_en), '0);
      chk("rst_addr", DW'(mem_addr), '0);
      chk("rst_clear", DW'(array_clear), '0);
      chk("rst_capture", DW'(result_capture), '0);
      chk("rst_valid", DW'(array_valid), '0);
      for (int i = 0; i < N; i++) chk($sformatf("rst_lane%0d_data", i), array_data[i], '0);
    end else begin
      eb = (cyc >= busy_from) && (cyc <= busy_until);
      chk("busy", DW'(busy), DW'(eb));
      chk("array_clear", DW'(array_clear), DW'(cyc == busy_from));
      ed = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("done", DW'(done), DW'(ed));
      chk("result_capture", DW'(result_capture), DW'(ed));
      if (ed) void'(done_q.pop_front());
      er = (addr_q.size() > 0) && (addr_q[0].cyc == cyc);
      chk("mem_rd_en", DW'(mem_rd_en), DW'(er));
      if (er) begin
        chk("mem_addr", DW'(mem_addr), addr_q[0].val);
        void'(addr_q.pop_front());
      end
      for (int i = 0; i < N; i++) begin
        ev = (lane_q[i].size() > 0) && (lane_q[i][0].cyc == cyc);
        chk($sformatf("lane%0d_valid", i), DW'(array_valid[i]), DW'(ev));
        if (ev) begin
          chk($sformatf("lane%0d_data", i), array_data[i], lane_q[i][0].val);
          void'(lane_q[i].pop_front());
        end else begin
          chk($sformatf("lane%0d_zero", i), array_data[i], '0);
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 256; a++)
      for (int i = 0; i < N; i++) mem[a][i] = $urandom();
    mem[0][0] = 1;
    mem[0][1] = 2;
    mem[1][0] = 3;
    mem[1][1] = 4;

    do_reset(3);

    // Single op from base 0: rows {1,2},{3,4}.
    step(1'b1, 8'h00);
    repeat (10) step(1'b0, 8'h00);

    // Address wrap.
    step(1'b1, 8'hFF);
    repeat (10) step(1'b0, 8'h00);

    // start held high; base changes every cycle while busy.
    for (int k = 0; k < 20; k++) step(1'b1, AW'(8'h40 + k));
    repeat (10) step(1'b0, 8'h00);

    // Reset in cycle 4 of an op, then a clean op.
    step(1'b1, 8'h10);
    repeat (3) step(1'b0, 8'h00);
    do_reset(2);
    step(1'b1, 8'h20);
    repeat (12) step(1'b0, 8'h00);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(1, 3)));
      else step($urandom_range(0, 2) == 0, AW'($urandom()));
    end
    repeat (LAT + 10) step(1'b0, 8'h00);

    chk("addr_q_empty", DW'(addr_q.size()), '0);
    chk("done_q_empty", DW'(done_q.size()), '0);
    for (int i = 0; i < N; i++) chk($sformatf("lane%0d_q_empty", i), DW'(lane_q[i].size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
